nor_cmd_seq: RTL

Command sequencer that turns high-level NOR flash operations (read, word program, sector erase, reset) into the JEDEC unlock/command word sequences. It drives them as a pipelined Wishbone master into the NOR bus adapter, then supervises the flash ready/busy line until the operation completes. It sits between the host-side register/command logic and the NOR bus adapter, and is the only master on that bus.

---
 rtl/nor_cmd_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/nor_cmd_seq.sv
// NOR flash command sequencer: expands READ/PROGRAM/SECTOR_ERASE/RESET into JEDEC
// word sequences on a pipelined Wishbone master, then waits for ready/busy.
module nor_cmd_seq #(
    parameter int unsigned ADDRBITS = 26,
    parameter int unsigned DATABITS = 16,
    parameter int unsigned SETTLE   = 16,
    parameter logic [23:0] TIMEOUT  = 24'd1000000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [ADDRBITS-1:0] cmd_addr_i,
    input  logic [DATABITS-1:0] cmd_data_i,
    output logic                rsp_valid_o,
    output logic [DATABITS-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDRBITS-1:0] wbm_adr_o,
    output logic [DATABITS-1:0] wbm_dat_o,
    input  logic [DATABITS-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_stall_i,
    input  logic                nor_ry_i
);
    localparam int unsigned CNTW = 24;
    localparam logic [CNTW-1:0] SETTLE_LAST  = (SETTLE == 0) ? '0 : CNTW'(SETTLE - 32'd1);
    localparam logic [CNTW-1:0] TIMEOUT_LAST = (TIMEOUT == '0) ? '0 : TIMEOUT - 24'd1;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_PROG  = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;

    localparam logic [ADDRBITS-1:0] A_555 = ADDRBITS'(12'h555);
    localparam logic [ADDRBITS-1:0] A_2AA = ADDRBITS'(12'h2AA);
    localparam logic [DATABITS-1:0] D_AA  = DATABITS'(8'hAA);
    localparam logic [DATABITS-1:0] D_55  = DATABITS'(8'h55);
    localparam logic [DATABITS-1:0] D_A0  = DATABITS'(8'hA0);
    localparam logic [DATABITS-1:0] D_80  = DATABITS'(8'h80);
    localparam logic [DATABITS-1:0] D_30  = DATABITS'(8'h30);
    localparam logic [DATABITS-1:0] D_F0  = DATABITS'(8'hF0);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_SETTLE, S_POLL, S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic [1:0]           op_q, op_d;
    logic [ADDRBITS-1:0]  addr_q, addr_d;
    logic [DATABITS-1:0]  data_q, data_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [2:0]           last_step;
    logic                 err_d;
    logic [DATABITS-1:0]  rdata_d;
    logic                 seq_we;
    logic [ADDRBITS-1:0]  seq_adr;
    logic [DATABITS-1:0]  seq_dat;

    // Final step index of the latched operation
    always_comb begin
        last_step = 3'd0;
        case (op_q)
            OP_PROG:  last_step = 3'd3;
            OP_ERASE: last_step = 3'd5;
            default:  last_step = 3'd0;
        endcase
    end

    // Sequence table lookup for the word about to be issued
    always_comb begin
        seq_we  = 1'b1;
        seq_adr = A_555;
        seq_dat = D_AA;
        case (op_d)
            OP_READ: begin
                seq_we  = 1'b0;
                seq_adr = addr_d;
                seq_dat = '0;
            end
            OP_PROG: begin
                case (step_d)
                    3'd0: ;
                    3'd1: begin seq_adr = A_2AA; seq_dat = D_55; end
                    3'd2: seq_dat = D_A0;
                    default: begin seq_adr = addr_d; seq_dat = data_d; end
                endcase
            end
            OP_ERASE: begin
                case (step_d)
                    3'd0, 3'd3: ;
                    3'd1, 3'd4: begin seq_adr = A_2AA; seq_dat = D_55; end
                    3'd2: seq_dat = D_80;
                    default: begin seq_adr = addr_d; seq_dat = D_30; end
                endcase
            end
            default: begin
                seq_adr = '0;
                seq_dat = D_F0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d = S_ISSUE;
                    step_d  = 3'd0;
                    op_d    = cmd_op_i;
                    addr_d  = cmd_addr_i;
                    data_d  = cmd_data_i;
                end
            end
            S_ISSUE: begin
                if (!wbm_stall_i) begin
                    state_d = S_WAIT_ACK;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                // An ack in the expiry cycle still counts
                if (wbm_ack_i) begin
                    if (step_q != last_step) begin
                        step_d  = step_q + 3'd1;
                        state_d = S_ISSUE;
                    end else if (op_q == OP_READ) begin
                        rdata_d = wbm_dat_i;
                        state_d = S_RESP;
                    end else if (op_q == OP_RESET) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_POLL;
            end
            S_POLL: begin
                if (nor_ry_i) begin
                    state_d = S_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 24'd1;
    end

    // State and registered outputs; outputs reflect the state being entered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            cmd_ready_o <= (state_d == S_IDLE);
            rsp_valid_o <= (state_d == S_RESP);
            rsp_err_o   <= err_d;
            rsp_data_o  <= rdata_d;
            wbm_cyc_o   <= (state_d == S_ISSUE) || (state_d == S_WAIT_ACK) ||
                           (state_d == S_SETTLE) || (state_d == S_POLL);
            wbm_stb_o   <= (state_d == S_ISSUE);
            wbm_we_o    <= (state_d == S_ISSUE) && seq_we;
            wbm_adr_o   <= (state_d == S_ISSUE) ? seq_adr : '0;
            wbm_dat_o   <= (state_d == S_ISSUE) ? seq_dat : '0;
        end
    end

endmodule
